// File: rtl/eth_filter_pkg.sv
// -----------------------------------------------------------------------------
// eth_filter_pkg
// Shared types and constants for the Ethernet RX destination-address filter.
//   state_t    : filter state machine encoding (HDR, REPLAY, PASS, DROP)
//   filt_cfg_t : per-frame configuration snapshot (station address + modes)
//   HDR_LEN    : number of destination-address bytes buffered before deciding
//   BCAST_ADDR : broadcast destination address
// -----------------------------------------------------------------------------
package eth_filter_pkg;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_REPLAY = 2'd1,
    ST_PASS   = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [47:0] mac_addr;
    logic        promisc;
    logic        accept_mcast;
  } filt_cfg_t;

  localparam int          HDR_LEN    = 6;
  localparam logic [2:0]  LAST_IDX   = 3'(HDR_LEN - 1);
  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_dest_match.sv
// -----------------------------------------------------------------------------
// eth_dest_match
// Purely combinational destination-address acceptance decision.
// Ports:
//   dest         in  48  destination address, dest[47:40] = first byte on wire
//   mac_addr     in  48  station address to compare against
//   promisc      in  1   accept everything
//   accept_mcast in  1   accept group addresses (I/G bit of first byte set)
//   match        out 1   frame is to be forwarded
// -----------------------------------------------------------------------------
module eth_dest_match
  import eth_filter_pkg::*;
(
  input  logic [47:0] dest,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        accept_mcast,
  output logic        match
);

  logic is_unicast_hit;
  logic is_bcast;
  logic is_mcast;

  assign is_unicast_hit = (dest == mac_addr);
  assign is_bcast       = (dest == BCAST_ADDR);
  // The I/G bit is bit 0 of the first byte on the wire, i.e. dest[40].
  assign is_mcast       = accept_mcast & dest[40];

  assign match = promisc | is_unicast_hit | is_bcast | is_mcast;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// -----------------------------------------------------------------------------
// eth_rx_mac_filter
// AXI-Stream (8-bit) receive filter. Buffers the 6 destination-address bytes of
// each frame, decides accept/drop, then either replays the buffered bytes and
// passes the rest of the frame through combinationally, or swallows the frame.
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   mac_addr[47:0]          station address (mac_addr[47:40] = first byte)
//   promisc                 accept all frames
//   accept_mcast            accept group-addressed frames
//   s_axis_t*               upstream stream (tkeep ignored)
//   m_axis_t*               filtered stream (tkeep always 1)
//   drop_count[31:0]        dropped-frame counter, present only when the
//                           ETH_RX_FILTER_CNT_EN macro is defined
//
// Configuration macro: ETH_RX_FILTER_CNT_EN (adds the drop_count port/counter).
// -----------------------------------------------------------------------------
module eth_rx_mac_filter
  import eth_filter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        accept_mcast,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
`ifdef ETH_RX_FILTER_CNT_EN
  ,
  output logic [31:0] drop_count
`endif
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q;
  logic [2:0]  ridx_q;
  logic [7:0]  hdr_buf [0:HDR_LEN-1];
  filt_cfg_t   cfg_q;
  logic [47:0] hdr_dest;
  logic        match;
  logic        unused_tkeep;

  assign unused_tkeep = s_axis_tkeep;
  assign m_axis_tkeep = 1'b1;

  // The decision is taken in the same cycle byte 5 arrives, so the last
  // address byte comes straight from the input rather than from the buffer.
  assign hdr_dest = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3],
                     hdr_buf[4], s_axis_tdata};

  eth_dest_match u_dest_match (
    .dest         (hdr_dest),
    .mac_addr     (cfg_q.mac_addr),
    .promisc      (cfg_q.promisc),
    .accept_mcast (cfg_q.accept_mcast),
    .match        (match)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first; a missed branch would otherwise
    // infer a latch.
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        s_axis_tready = 1'b1;
        // A tlast inside the header is a runt: stay here and restart at byte 0.
        if (s_axis_tvalid && !s_axis_tlast && (idx_q == LAST_IDX)) begin
          state_d = match ? ST_REPLAY : ST_DROP;
        end
      end

      ST_REPLAY: begin
        // Input is stalled while the buffered header drains, so tvalid is
        // held high until each byte is taken.
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_buf[ridx_q];
        if (m_axis_tready && (ridx_q == LAST_IDX)) begin
          state_d = ST_PASS;
        end
      end

      ST_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = ST_HDR;
        end
      end

      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_HDR;
        end
      end

      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Header capture, replay index and per-frame configuration snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      ridx_q <= '0;
      cfg_q  <= '0;
      // NOTE: this small header buffer is reset on purpose so that replayed
      // data is deterministic after reset; large data memories normally are not.
      for (int i = 0; i < HDR_LEN; i++) begin
        hdr_buf[i] <= 8'h00;
      end
    end else begin
      unique case (state_q)
        ST_HDR: begin
          if (s_axis_tvalid) begin
            hdr_buf[idx_q] <= s_axis_tdata;
            if (idx_q == 3'd0) begin
              cfg_q <= '{mac_addr: mac_addr, promisc: promisc,
                         accept_mcast: accept_mcast};
            end
            if (s_axis_tlast || (idx_q == LAST_IDX)) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end

        ST_REPLAY: begin
          if (m_axis_tready) begin
            ridx_q <= (ridx_q == LAST_IDX) ? 3'd0 : ridx_q + 3'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

`ifdef ETH_RX_FILTER_CNT_EN
  // ---------------------------------------------------------------------------
  // Dropped-frame counter: runts ending in HDR and rejected frames ending in
  // DROP. Wraps naturally at 2^32.
  // ---------------------------------------------------------------------------
  logic drop_evt;

  assign drop_evt = s_axis_tvalid && s_axis_tlast &&
                    ((state_q == ST_HDR) || (state_q == ST_DROP));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop_evt) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/eth_rx_mac_filter.md
ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 SHALL have parameter-free ports; station address and mode are run-time inputs.
REQ-002 clock  in  1  single clock for all logic; same domain as the MAC RX_AXIS (125 MHz).
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 mac_addr  in  48  station address; mac_addr[47:40] is the first destination byte on the wire.
REQ-005 promisc  in  1  accept all frames regardless of destination.
REQ-006 accept_mcast  in  1  accept frames whose destination byte 0 bit 0 is 1.
REQ-007 s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  8/1/1/1/1/1  upstream RX stream from the MAC FIFO.
REQ-008 m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  8/1/1/1/1/1  filtered stream to the DMA/host side.

Function
REQ-009 SHALL implement four states: HDR, REPLAY, PASS, DROP.
REQ-010 HDR: s_axis_tready=1, m_axis_tvalid=0; each accepted byte is stored in hdr_buf[idx], idx=0..5.
REQ-011 HDR: mac_addr, promisc and accept_mcast SHALL be latched on acceptance of byte 0 and held for the whole frame.
REQ-012 HDR: tlast accepted at idx<=5 (frame of 6 bytes or fewer) SHALL discard the frame, bump the drop count and stay in HDR with idx=0.
REQ-013 HDR: on accepting byte 5 without tlast, match = promisc | dest==latched mac_addr | dest==FF:FF:FF:FF:FF:FF | (accept_mcast & hdr_buf[0][0]).
REQ-014 HDR: match SHALL go to REPLAY, no match SHALL go to DROP, in the cycle after byte 5.
REQ-015 REPLAY: m_axis_tvalid=1, m_axis_tdata=hdr_buf[ridx], tlast=0, tuser=0, s_axis_tready=0; ridx advances on m_axis handshake.
REQ-016 REPLAY: handshake of ridx=5 SHALL go to PASS.
REQ-017 PASS: combinational pass-through; m_axis_{tdata,tvalid,tlast,tuser}=s_axis_*, s_axis_tready=m_axis_tready.
REQ-018 PASS: handshake with tlast=1 SHALL go to HDR with idx=0.
REQ-019 DROP: s_axis_tready=1, m_axis_tvalid=0; accepted tlast SHALL bump the drop count and go to HDR.
REQ-020 m_axis_tkeep SHALL always be 1; s_axis_tkeep is ignored.
REQ-021 tuser (bad frame) SHALL be forwarded unchanged on the last byte of passed frames; the filter does not judge it.
REQ-022 m_axis_tvalid SHALL never fall without a handshake while in REPLAY (AXI-Stream stability).
REQ-023 Latency: the first output byte is valid in the cycle after byte 5 is accepted; overhead is 6 input-stall cycles per passed frame.
REQ-024 m_axis_tready low in REPLAY or PASS SHALL stall with no data loss or duplication.

Reset
REQ-025 Reset SHALL force state=HDR, idx=ridx=0, m_axis_tvalid=0, s_axis_tready=1 (from HDR), hdr_buf=0, and latched config=0.
REQ-026 Reset mid-frame SHALL abandon the frame; the first byte after reset release is treated as byte 0 (upstream shares the reset).

Configuration
REQ-027 Macro ETH_RX_FILTER_CNT_EN defined: adds output drop_count[31:0], reset to 0, +1 per dropped frame (REQ-012, REQ-019), wrapping at 2^32.
REQ-028 Macro ETH_RX_FILTER_CNT_EN undefined: no drop_count port and no counter logic; all other behaviour is identical.

Structure
REQ-029 Package eth_filter_pkg SHALL hold the state enum, HDR_LEN=6 and BCAST_ADDR=48'hFFFF_FFFF_FFFF.
REQ-030 Sub-module eth_dest_match (combinational address compare, REQ-013) SHALL be the only child.

Verification
REQ-031 mac_addr=02:00:00:00:00:01, frame dest 02:00:00:00:00:01 with 64 bytes, m_tready=1 -> identical 64 bytes out, tlast on byte 64, drop_count=0.
REQ-032 Same mac_addr, dest 02:00:00:00:00:02, promisc=0 -> no m_axis_tvalid, 64 bytes consumed, drop_count=1; with promisc=1 -> passed.
REQ-033 Dest FF:FF:FF:FF:FF:FF -> passed; dest 01:00:5E:00:00:01 -> passed only when accept_mcast=1.
REQ-034 4-byte frame with tlast on byte 3 -> dropped, drop_count+1; the next 60-byte matching frame passes intact.
REQ-035 Random m_tready (50%) and s_tvalid gaps over 100 frames -> output equals the golden filtered stream byte-for-byte, tuser preserved.
REQ-036 reset_n asserted in PASS at byte 20 -> outputs at reset values immediately; a following good frame passes correctly.
